coin_pulse_gen: RTL and testbench
=================================

# coin_pulse_gen

Front-end coin conditioner for the vending controller. It takes the raw, asynchronous, bouncy nickel and dime sensor levels and synchronizes and debounces them. It emits single-cycle `Ni`/`Di` pulses that feed the coin-accumulation state machine directly. It guarantees that the downstream state machine sees at most one coin pulse per clock and exactly one pulse per physical coin insertion.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive synchronized samples a new level must hold before it is accepted; legal range 1–255.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  asynchronous, active-high reset; clears all state immediately.
- `nickel_raw`  in  1  raw nickel sensor level, asynchronous to `clk`, high while coin present.
- `dime_raw`  in  1  raw dime sensor level, asynchronous to `clk`, high while coin present.
- `Ni`  out  1  registered one-cycle nickel pulse to the core logic.
- `Di`  out  1  registered one-cycle dime pulse to the core logic.

## Operation
- Per channel, a two-flop synchronizer (`s1`, `s2`) is followed by a debounced level `db` and a counter `cnt` (8 bits).
- Debounce, each edge:
  - if `s2 == db`, set `cnt <= 0`;
  - else if `cnt == DEBOUNCE_CYCLES-1`, set `db <= s2` and `cnt <= 0`;
  - else `cnt <= cnt+1`.
- Any glitch back to `db` before the count completes restarts the count.
- Rising-edge detect: `rise = (db_next & ~db)`. Falling edges produce no pulse.
- A coin held high indefinitely yields one pulse. The next pulse on that channel requires a debounced low followed by a debounced high.
- Arbitration FSM, states IDLE and DIME_PEND:
  - IDLE, nickel rise only: `Ni=1` next cycle.
  - IDLE, dime rise only: `Di=1` next cycle.
  - IDLE, both rise on the same edge: `Ni=1` next cycle, go to DIME_PEND.
  - DIME_PEND: `Di=1` for one cycle, return to IDLE unconditionally.
  - A nickel rise cannot occur in DIME_PEND, because the nickel debounced level was just set high.
  - A second dime rise in DIME_PEND is impossible for the same reason.
- `Ni` and `Di` are never high in the same cycle.
- Reset values: `s1`, `s2`, `db`, `cnt` = 0; FSM = IDLE; `Ni` = 0; `Di` = 0. Both debounced levels reset low.
- Raw inputs that are already high when reset deasserts are treated as new insertions and produce a pulse after the normal latency.

## Timing
- Let edge 1 be the first `clk` edge that samples a raw input high.
  - `s1` goes high at edge 1 and `s2` at edge 2.
  - `db` and the registered pulse update at edge `2+DEBOUNCE_CYCLES`.
  - The pulse is high for the one cycle after that edge.
- Default latency: the pulse is high after edge 6 and drops after edge 7.
- In the simultaneous case, `Di` follows `Ni` one cycle later.
- Release latency, from raw low to `db` low, is the same `2+DEBOUNCE_CYCLES` edges.
- Reset mid-debounce or in DIME_PEND discards the pending count and the pending dime. No pulse is emitted.
- Reset is asynchronous: outputs go low without waiting for a clock.
- Minimum legal spacing between two coins on one channel is `2*DEBOUNCE_CYCLES` cycles: a debounced low period followed by a debounced high period.

## Configuration
- `COIN_SIMUL_REJECT_EN`
- **Undefined (default):** simultaneous nickel and dime rises are serialized, nickel first, through DIME_PEND as described above.
- **Defined:**
  - Simultaneous rises are treated as a jam and both are discarded: no `Ni`, no `Di`, FSM stays IDLE.
  - The DIME_PEND state is not compiled in.
  - Single-channel behaviour is unchanged.

## Test plan
- **Clean nickel:** with `DEBOUNCE_CYCLES=4` and reset released, raise `nickel_raw` before edge 1 and hold it 20 cycles. Required: `Ni` is high for exactly the cycle after edge 6, `Di` stays 0, and there is no further pulse while held.
- **Bounce:** toggle `dime_raw` high 2 cycles, low 1, high 2, low 1, then high steady. Required: exactly one `Di` pulse, 6 edges after the final rise; none during the bouncing.
- **Simultaneous, macro undefined:** raise both raw inputs on the same cycle. Required: `Ni=1` after edge 6 and `Di=1` after edge 7, never overlapping. With `COIN_SIMUL_REJECT_EN` defined, neither pulse appears.
- **Repeat coin:** nickel high 10 cycles, low 10, high 10. Required: two `Ni` pulses, 20 cycles apart.
- **Reset mid-operation:**
  - Assert `reset` at edge 4 of a dime insertion. Required: `Di` stays 0.
  - After deassertion with `dime_raw` still high, `Di` pulses 6 edges later.
- **Reset in DIME_PEND:** assert `reset` asynchronously during the `Ni` cycle of a simultaneous insertion. Required: `Ni` drops immediately and no `Di` follows.

Source files
------------

// File: rtl/coin_pulse_gen_if.sv
// Coin sensor / pulse bundle between the raw sensor side and the coin conditioner.
// master = sensor/driver side, slave = conditioner side.
interface coin_pulse_gen_if;
  logic nickel_raw;
  logic dime_raw;
  logic Ni;
  logic Di;

  modport master (output nickel_raw, output dime_raw, input Ni, input Di);
  modport slave  (input nickel_raw, input dime_raw, output Ni, output Di);
endinterface

// File: rtl/coin_pulse_gen.sv
// Coin conditioner: per-channel sync + debounce, then arbitration into single-cycle Ni/Di pulses.
// Optional macro COIN_SIMUL_REJECT_EN: discard simultaneous nickel+dime rises as a jam.
module coin_chan #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic raw_i,
  output logic rise_o
);
  localparam logic [7:0] CNT_MAX = 8'(DEBOUNCE_CYCLES - 1);

  logic       s1_q, s2_q;
  logic       db_q, db_d;
  logic [7:0] cnt_q, cnt_d;

  always_comb begin
    db_d  = db_q;
    cnt_d = 8'd0;
    if (s2_q != db_q) begin
      if (cnt_q == CNT_MAX) db_d  = s2_q;
      else                  cnt_d = cnt_q + 8'd1;
    end
  end

  assign rise_o = db_d & ~db_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q  <= 1'b0;
      s2_q  <= 1'b0;
      db_q  <= 1'b0;
      cnt_q <= 8'd0;
    end else begin
      s1_q  <= raw_i;
      s2_q  <= s1_q;
      db_q  <= db_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

module coin_pulse_gen #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic              clk,
  input  logic              reset,
  coin_pulse_gen_if.slave   bus
);
  localparam int NUM_CH = 2;

  // Channel 0 = nickel, channel 1 = dime.
  logic [NUM_CH-1:0] raw, rise;
  assign raw = {bus.dime_raw, bus.nickel_raw};

  for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
    coin_chan #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_chan (
      .clk    (clk),
      .reset  (reset),
      .raw_i  (raw[g]),
      .rise_o (rise[g])
    );
  end

`ifdef COIN_SIMUL_REJECT_EN
  typedef enum logic {IDLE = 1'b0} state_t;
`else
  typedef enum logic {IDLE = 1'b0, DIME_PEND = 1'b1} state_t;
`endif

  state_t state_q, state_d;
  logic   ni_q, ni_d, di_q, di_d;

  always_comb begin
    state_d = state_q;
    ni_d    = 1'b0;
    di_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (rise[0] && rise[1]) begin
`ifdef COIN_SIMUL_REJECT_EN
          // Jam: both coins dropped, FSM stays put.
          state_d = IDLE;
`else
          ni_d    = 1'b1;
          state_d = DIME_PEND;
`endif
        end else if (rise[0]) begin
          ni_d = 1'b1;
        end else if (rise[1]) begin
          di_d = 1'b1;
        end
      end
`ifndef COIN_SIMUL_REJECT_EN
      // Both debounced levels are already high here, so no new rise can arrive.
      DIME_PEND: begin
        di_d    = 1'b1;
        state_d = IDLE;
      end
`endif
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      ni_q    <= 1'b0;
      di_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      ni_q    <= ni_d;
      di_q    <= di_d;
    end
  end

  assign bus.Ni = ni_q;
  assign bus.Di = di_q;
endmodule

// File: tb/tb_coin_pulse_gen.sv
// Directed bench for coin_pulse_gen (DEBOUNCE_CYCLES=4); expectations hand-derived edge by edge.
module tb_coin_pulse_gen;
  logic clk = 1'b0;
  logic reset;
  coin_pulse_gen_if bus();

  coin_pulse_gen #(.DEBOUNCE_CYCLES(4)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int edge_n, n_cnt, d_cnt, n_first, d_first, n_last, overlap;

  task automatic chk(input string tag, input int obs, input int exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    edge_n = 0; n_cnt = 0; d_cnt = 0;
    n_first = -1; d_first = -1; n_last = -1;
  endtask

  // Advance n edges, sampling #1 after each; edge_n counts edges since clr().
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(posedge clk); #1;
      edge_n++;
      if (bus.Ni === 1'b1) begin
        n_cnt++; n_last = edge_n;
        if (n_first < 0) n_first = edge_n;
      end
      if (bus.Di === 1'b1) begin
        d_cnt++;
        if (d_first < 0) d_first = edge_n;
      end
      if (bus.Ni === 1'b1 && bus.Di === 1'b1) overlap++;
    end
  endtask

  initial begin
    overlap = 0;
    reset = 1'b1;
    bus.nickel_raw = 1'b0;
    bus.dime_raw   = 1'b0;
    clr();
    run(3);
    chk("reset_Ni", int'(bus.Ni), 0);
    chk("reset_Di", int'(bus.Di), 0);
    reset = 1'b0;
    run(2);

    // Clean nickel held 26 edges: one pulse right after edge 6.
    clr(); bus.nickel_raw = 1'b1;
    run(26);
    chk("clean_n_cnt", n_cnt, 1);
    chk("clean_n_edge", n_first, 6);
    chk("clean_d_cnt", d_cnt, 0);
    clr(); bus.nickel_raw = 1'b0;
    run(10);
    chk("release_n_cnt", n_cnt, 0);

    // Bounce: final rise at edge 6 of this sequence, pulse at edge 12.
    clr();
    bus.dime_raw = 1'b1; run(2);
    bus.dime_raw = 1'b0; run(1);
    bus.dime_raw = 1'b1; run(2);
    bus.dime_raw = 1'b0; run(1);
    bus.dime_raw = 1'b1; run(20);
    chk("bounce_d_cnt", d_cnt, 1);
    chk("bounce_d_edge", d_first, 12);
    chk("bounce_n_cnt", n_cnt, 0);
    clr(); bus.dime_raw = 1'b0;
    run(10);
    chk("bounce_release", d_cnt, 0);

    // Simultaneous rise.
    clr(); bus.nickel_raw = 1'b1; bus.dime_raw = 1'b1;
    run(20);
`ifdef COIN_SIMUL_REJECT_EN
    chk("simul_n_cnt", n_cnt, 0);
    chk("simul_d_cnt", d_cnt, 0);
`else
    chk("simul_n_cnt", n_cnt, 1);
    chk("simul_d_cnt", d_cnt, 1);
    chk("simul_n_edge", n_first, 6);
    chk("simul_d_edge", d_first, 7);
`endif
    clr(); bus.nickel_raw = 1'b0; bus.dime_raw = 1'b0;
    run(10);

    // Repeat coin: rises sampled at edges 1 and 21, pulses at 6 and 26.
    clr();
    bus.nickel_raw = 1'b1; run(10);
    bus.nickel_raw = 1'b0; run(10);
    bus.nickel_raw = 1'b1; run(15);
    chk("repeat_n_cnt", n_cnt, 2);
    chk("repeat_n_first", n_first, 6);
    chk("repeat_spacing", n_last - n_first, 20);
    clr(); bus.nickel_raw = 1'b0;
    run(10);

    // Reset asserted after edge 3, so it is high at edge 4 of the insertion.
    clr(); bus.dime_raw = 1'b1;
    run(3);
    reset = 1'b1;
    run(5);
    chk("rst_mid_d_cnt", d_cnt, 0);
    clr(); reset = 1'b0;
    run(12);
    chk("rst_mid_after_cnt", d_cnt, 1);
    chk("rst_mid_after_edge", d_first, 6);
    clr(); bus.dime_raw = 1'b0;
    run(10);

    // Reset asynchronously during the Ni cycle of a simultaneous insertion.
    clr(); bus.nickel_raw = 1'b1; bus.dime_raw = 1'b1;
    run(6);
`ifdef COIN_SIMUL_REJECT_EN
    chk("pend_ni_before", int'(bus.Ni), 0);
`else
    chk("pend_ni_before", int'(bus.Ni), 1);
`endif
    #2 reset = 1'b1;
    #1;
    chk("pend_async_Ni", int'(bus.Ni), 0);
    chk("pend_async_Di", int'(bus.Di), 0);
    run(2);
    bus.nickel_raw = 1'b0; bus.dime_raw = 1'b0;
    run(2);
    clr(); reset = 1'b0;
    run(15);
    chk("pend_after_d_cnt", d_cnt, 0);
    chk("pend_after_n_cnt", n_cnt, 0);

    chk("no_overlap", overlap, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
